// File: rtl/mmu_sv32_tlb.sv
// Sv32 translation unit: fully-associative TLB in front of a two-level hardware page-table walker.
// Bare mode passes addresses through. Permission violations come back as page faults.
module mmu_sv32_tlb #(
  parameter int unsigned TLB_ENTRIES  = 4,
  parameter bit          SUPERPAGE_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SATP_MODE,
  input  logic [21:0] SATP_PPN,
  input  logic        FLUSH,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_VADDR,
  input  logic [1:0]  REQ_ACC,
  output logic        RESP_VALID,
  output logic [31:0] RESP_PADDR,
  output logic        RESP_FAULT,
  output logic        MEM_TRANS_RDEN,
  output logic [31:0] MEM_TRANS_RIADDR,
  input  logic [31:0] MEM_TRANS_ROADDR,
  input  logic        MEM_TRANS_RVALID,
  input  logic [31:0] MEM_TRANS_RDATA
);

  localparam int unsigned IdxW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  typedef enum logic [2:0] {StIdle, StLookup, StWalk1, StWalk0, StResp} state_e;

  state_e      state_q;
  logic [31:0] vaddr_q;
  logic [1:0]  acc_q;
  logic        mode_q;
  logic [19:0] satp_ppn_q;   // bits above 19 only feed PA bits [33:32], which are dropped
  logic        rden_q;
  logic [31:0] riaddr_q;
  logic        resp_valid_q;
  logic [31:0] resp_paddr_q;
  logic        resp_fault_q;
  logic        drop_q;       // a flush hit this walk: respond but do not fill

  logic [TLB_ENTRIES-1:0] tlb_valid_q;
  logic [9:0]             tlb_vpn1_q [TLB_ENTRIES];
  logic [9:0]             tlb_vpn0_q [TLB_ENTRIES];
  logic [19:0]            tlb_ppn_q  [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] tlb_super_q;
  logic [TLB_ENTRIES-1:0] tlb_r_q;
  logic [TLB_ENTRIES-1:0] tlb_w_q;
  logic [TLB_ENTRIES-1:0] tlb_x_q;
  logic [TLB_ENTRIES-1:0] tlb_a_q;
  logic [TLB_ENTRIES-1:0] tlb_d_q;
  logic [IdxW-1:0]        rr_q;

  // Required permission bit for the access type, plus A; stores also need D.
  function automatic logic perm_ok(input logic [1:0] acc, input logic r, input logic w,
                                   input logic x, input logic a, input logic d);
    case (acc)
      2'd0:    perm_ok = x & a;
      2'd2:    perm_ok = w & d & a;
      default: perm_ok = r & a;
    endcase
  endfunction

  logic        hit;
  logic        hit_perm;
  logic [31:0] hit_paddr;

  // Associative lookup; the first matching entry wins.
  always_comb begin
    hit       = 1'b0;
    hit_perm  = 1'b0;
    hit_paddr = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (!hit && tlb_valid_q[i] && (tlb_vpn1_q[i] == vaddr_q[31:22]) &&
          (tlb_super_q[i] || (tlb_vpn0_q[i] == vaddr_q[21:12]))) begin
        hit       = 1'b1;
        hit_perm  = perm_ok(acc_q, tlb_r_q[i], tlb_w_q[i], tlb_x_q[i], tlb_a_q[i], tlb_d_q[i]);
        hit_paddr = tlb_super_q[i] ? {tlb_ppn_q[i][19:10], vaddr_q[21:0]}
                                   : {tlb_ppn_q[i], vaddr_q[11:0]};
      end
    end
  end

  logic        pte_take;
  logic        pte_v, pte_r, pte_w, pte_x, pte_a, pte_d;
  logic [21:0] pte_ppn;
  logic        pte_invalid;
  logic        pte_leaf;
  logic        super_ok;
  logic        walk_perm;
  logic        fill_en;
  logic [31:0] l1_addr;
  logic [31:0] l0_addr;

  // PTE decode, walk addresses and TLB fill decision.
  always_comb begin
    pte_take    = MEM_TRANS_RVALID && (MEM_TRANS_ROADDR == riaddr_q) &&
                  ((state_q == StWalk1) || (state_q == StWalk0));
    pte_v       = MEM_TRANS_RDATA[0];
    pte_r       = MEM_TRANS_RDATA[1];
    pte_w       = MEM_TRANS_RDATA[2];
    pte_x       = MEM_TRANS_RDATA[3];
    pte_a       = MEM_TRANS_RDATA[6];
    pte_d       = MEM_TRANS_RDATA[7];
    pte_ppn     = MEM_TRANS_RDATA[31:10];
    pte_invalid = !pte_v || (!pte_r && pte_w);
    pte_leaf    = pte_r || pte_x;
    super_ok    = SUPERPAGE_EN && (pte_ppn[9:0] == 10'd0);
    walk_perm   = perm_ok(acc_q, pte_r, pte_w, pte_x, pte_a, pte_d);
    // Sums are taken modulo 2^32, so only the low PPN bits matter.
    l1_addr     = {satp_ppn_q, 12'b0} + {20'b0, vaddr_q[31:22], 2'b0};
    l0_addr     = {pte_ppn[19:0], 12'b0} + {20'b0, vaddr_q[21:12], 2'b0};
    fill_en     = pte_take && !drop_q && !FLUSH && !pte_invalid && pte_leaf &&
                  ((state_q == StWalk0) || super_ok);
  end

  // Control FSM with registered response and memory-request outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      vaddr_q      <= '0;
      acc_q        <= '0;
      mode_q       <= 1'b0;
      satp_ppn_q   <= '0;
      rden_q       <= 1'b0;
      riaddr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_paddr_q <= '0;
      resp_fault_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (FLUSH && ((state_q == StWalk1) || (state_q == StWalk0))) drop_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (REQ_VALID) begin
            vaddr_q    <= REQ_VADDR;
            acc_q      <= REQ_ACC;
            mode_q     <= SATP_MODE;
            satp_ppn_q <= SATP_PPN[19:0];
            state_q    <= StLookup;
          end
        end
        StLookup: begin
          if (!mode_q) begin
            resp_valid_q <= 1'b1;
            resp_paddr_q <= vaddr_q;
            resp_fault_q <= 1'b0;
            state_q      <= StResp;
          end else if (hit) begin
            resp_valid_q <= 1'b1;
            resp_paddr_q <= hit_perm ? hit_paddr : 32'd0;
            resp_fault_q <= !hit_perm;
            state_q      <= StResp;
          end else begin
            rden_q   <= 1'b1;
            riaddr_q <= l1_addr;
            state_q  <= StWalk1;
          end
        end
        StWalk1: begin
          if (pte_take) begin
            if (!pte_invalid && !pte_leaf) begin
              riaddr_q <= l0_addr;
              state_q  <= StWalk0;
            end else begin
              rden_q       <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
              if (pte_invalid || !super_ok || !walk_perm) begin
                resp_paddr_q <= '0;
                resp_fault_q <= 1'b1;
              end else begin
                resp_paddr_q <= {pte_ppn[19:10], vaddr_q[21:0]};
                resp_fault_q <= 1'b0;
              end
            end
          end
        end
        StWalk0: begin
          if (pte_take) begin
            rden_q       <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
            if (pte_invalid || !pte_leaf || !walk_perm) begin
              resp_paddr_q <= '0;
              resp_fault_q <= 1'b1;
            end else begin
              resp_paddr_q <= {pte_ppn[19:0], vaddr_q[11:0]};
              resp_fault_q <= 1'b0;
            end
          end
        end
        StResp: begin
          drop_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Valid bits and replacement pointer; a flush overrides a same-edge fill.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tlb_valid_q <= '0;
      rr_q        <= '0;
    end else begin
      if (fill_en) begin
        tlb_valid_q[rr_q] <= 1'b1;
        rr_q              <= rr_q + 1'b1;
      end
      if (FLUSH) tlb_valid_q <= '0;
    end
  end

  // Entry payload, qualified by the valid bits so it needs no reset.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tlb_vpn1_q[rr_q]  <= vaddr_q[31:22];
      tlb_vpn0_q[rr_q]  <= vaddr_q[21:12];
      tlb_ppn_q[rr_q]   <= pte_ppn[19:0];
      tlb_super_q[rr_q] <= (state_q == StWalk1);
      tlb_r_q[rr_q]     <= pte_r;
      tlb_w_q[rr_q]     <= pte_w;
      tlb_x_q[rr_q]     <= pte_x;
      tlb_a_q[rr_q]     <= pte_a;
      tlb_d_q[rr_q]     <= pte_d;
    end
  end

  // U/G/RSW bits and PPN bits above the 32-bit PA are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{SATP_PPN[21:20], MEM_TRANS_RDATA[31:30], MEM_TRANS_RDATA[9:8],
                         MEM_TRANS_RDATA[5:4]};

  assign REQ_READY        = (state_q == StIdle);
  assign RESP_VALID       = resp_valid_q;
  assign RESP_PADDR       = resp_paddr_q;
  assign RESP_FAULT       = resp_fault_q;
  assign MEM_TRANS_RDEN   = rden_q;
  assign MEM_TRANS_RIADDR = riaddr_q;

endmodule

// File: tb/tb_mmu_sv32_tlb.sv
// Directed bench for mmu_sv32_tlb. A second instance with superpages disabled runs in lockstep.
module tb_mmu_sv32_tlb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SATP_MODE;
  logic [21:0] SATP_PPN;
  logic        FLUSH;
  logic        REQ_VALID;
  logic [31:0] REQ_VADDR;
  logic [1:0]  REQ_ACC;
  logic [31:0] ROADDR;
  logic        RVALID;
  logic [31:0] RDATA;

  logic        req_ready, resp_valid, resp_fault, rden;
  logic [31:0] resp_paddr, riaddr;
  logic        b_req_ready, b_resp_valid, b_resp_fault, b_rden;
  logic [31:0] b_resp_paddr, b_riaddr;

  int n_vec = 0;
  int n_err = 0;
  int rden_cnt = 0;

  typedef struct {
    logic        got;
    int          lat;
    logic [31:0] pa;
    logic        flt;
    int          rdc;
    logic        pulse;
    logic        rdy1;
    logic        bflt;
    logic        mm_rden;
    logic [31:0] mm_riaddr;
    logic        mm_ready;
  } res_t;

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (rden) rden_cnt <= rden_cnt + 1;

  mmu_sv32_tlb #(.TLB_ENTRIES(4), .SUPERPAGE_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .SATP_MODE(SATP_MODE), .SATP_PPN(SATP_PPN), .FLUSH(FLUSH),
    .REQ_VALID(REQ_VALID), .REQ_READY(req_ready), .REQ_VADDR(REQ_VADDR), .REQ_ACC(REQ_ACC),
    .RESP_VALID(resp_valid), .RESP_PADDR(resp_paddr), .RESP_FAULT(resp_fault),
    .MEM_TRANS_RDEN(rden), .MEM_TRANS_RIADDR(riaddr), .MEM_TRANS_ROADDR(ROADDR),
    .MEM_TRANS_RVALID(RVALID), .MEM_TRANS_RDATA(RDATA)
  );

  mmu_sv32_tlb #(.TLB_ENTRIES(4), .SUPERPAGE_EN(1'b0)) dut_nosp (
    .CLK(CLK), .RST(RST), .SATP_MODE(SATP_MODE), .SATP_PPN(SATP_PPN), .FLUSH(FLUSH),
    .REQ_VALID(REQ_VALID), .REQ_READY(b_req_ready), .REQ_VADDR(REQ_VADDR), .REQ_ACC(REQ_ACC),
    .RESP_VALID(b_resp_valid), .RESP_PADDR(b_resp_paddr), .RESP_FAULT(b_resp_fault),
    .MEM_TRANS_RDEN(b_rden), .MEM_TRANS_RIADDR(b_riaddr), .MEM_TRANS_ROADDR(ROADDR),
    .MEM_TRANS_RVALID(RVALID), .MEM_TRANS_RDATA(RDATA)
  );

  task automatic do_reset();
    RST = 1'b0; FLUSH = 1'b0; REQ_VALID = 1'b0; RVALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // One request; serves up to two PTE reads (optionally with a flush before the second,
  // or a mismatched-address response before the first), then waits for the response.
  task automatic txn(input logic [31:0] va, input logic [1:0] acc, input logic mode,
                     input int npte, input logic [31:0] a0, input logic [31:0] d0,
                     input logic [31:0] a1, input logic [31:0] d1, input logic flush_w0,
                     input logic mism, output res_t r);
    int r0;
    logic [31:0] ea, ed;
    r = '{got: 1'b0, lat: 0, pa: '0, flt: 1'b0, rdc: 0, pulse: 1'b0, rdy1: 1'b0,
          bflt: 1'b0, mm_rden: 1'b0, mm_riaddr: '0, mm_ready: 1'b0};
    r0 = rden_cnt;
    SATP_MODE = mode; REQ_VADDR = va; REQ_ACC = acc; REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    r.rdy1 = req_ready;
    for (int k = 0; k < npte; k++) begin
      ea = (k == 0) ? a0 : a1;
      ed = (k == 0) ? d0 : d1;
      if (k == 1 && flush_w0) begin
        FLUSH = 1'b1; @(negedge CLK); FLUSH = 1'b0;
      end
      for (int t = 0; t < 20 && !rden; t++) @(negedge CLK);
      if (k == 0 && mism && rden) begin
        RVALID = 1'b1; ROADDR = ea ^ 32'h8; RDATA = 32'h0;
        @(negedge CLK);
        RVALID = 1'b0;
        r.mm_rden = rden; r.mm_riaddr = riaddr; r.mm_ready = req_ready;
      end
      if (rden) begin
        RVALID = 1'b1; ROADDR = ea; RDATA = ed;
        @(negedge CLK);
        RVALID = 1'b0;
      end
    end
    for (int t = 0; t < 30 && !resp_valid; t++) begin
      @(negedge CLK);
      r.lat++;
    end
    r.got  = resp_valid;
    r.pa   = resp_paddr;
    r.flt  = resp_fault;
    r.bflt = b_resp_valid & b_resp_fault;
    r.rdc  = rden_cnt - r0;
    @(negedge CLK);
    r.pulse = !resp_valid;
  endtask

  task automatic test_reset();
    RST = 1'b0; FLUSH = 1'b0; REQ_VALID = 1'b0; RVALID = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, resp_valid, resp_fault, rden} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, resp_valid, resp_fault, rden});
    end
    n_vec++;
    if (resp_paddr !== 32'h0 || riaddr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_addr: got paddr %h riaddr %h expected 0 0", resp_paddr, riaddr);
    end
    @(negedge CLK); RST = 1'b1; @(negedge CLK);
  endtask

  task automatic test_bare();
    res_t r;
    do_reset();
    txn(32'h12345678, 2'd1, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h12345678 || r.flt !== 1'b0) begin
      n_err++;
      $display("FAIL bare_pa: got v%b %h f%b expected v1 12345678 f0", r.got, r.pa, r.flt);
    end
    n_vec++;
    if (r.lat != 1 || r.rdc != 0) begin
      n_err++;
      $display("FAIL bare_timing: got lat %0d rden %0d expected lat 1 rden 0", r.lat, r.rdc);
    end
    n_vec++;
    if (r.rdy1 !== 1'b0 || r.pulse !== 1'b1) begin
      n_err++;
      $display("FAIL bare_handshake: got ready %b pulse %b expected 0 1", r.rdy1, r.pulse);
    end
  endtask

  task automatic test_two_level();
    res_t r;
    do_reset();
    txn(32'h00401234, 2'd1, 1'b1, 2, 32'h80004, 32'h00020401, 32'h81004, 32'h048D14C7,
        1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h12345234 || r.flt !== 1'b0 || r.lat != 0) begin
      n_err++;
      $display("FAIL walk_load: got v%b %h f%b lat %0d expected v1 12345234 f0 lat 0",
               r.got, r.pa, r.flt, r.lat);
    end
    txn(32'h00401234, 2'd1, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h12345234 || r.lat != 1 || r.rdc != 0) begin
      n_err++;
      $display("FAIL hit_load: got v%b %h lat %0d rden %0d expected v1 12345234 lat 1 rden 0",
               r.got, r.pa, r.lat, r.rdc);
    end
    txn(32'h00401ABC, 2'd2, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h12345ABC || r.flt !== 1'b0 || r.rdc != 0) begin
      n_err++;
      $display("FAIL hit_store: got v%b %h f%b expected v1 12345abc f0", r.got, r.pa, r.flt);
    end
    txn(32'h00401234, 2'd0, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h0 || r.flt !== 1'b1) begin
      n_err++;
      $display("FAIL hit_fetch_nox: got v%b %h f%b expected v1 0 f1", r.got, r.pa, r.flt);
    end
  endtask

  task automatic test_superpage();
    res_t r;
    do_reset();
    txn(32'h80001000, 2'd0, 1'b1, 1, 32'h80800, 32'h2000004B, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h80001000 || r.flt !== 1'b0 || r.lat != 0) begin
      n_err++;
      $display("FAIL super_fetch: got v%b %h f%b lat %0d expected v1 80001000 f0 lat 0",
               r.got, r.pa, r.flt, r.lat);
    end
    n_vec++;
    if (r.bflt !== 1'b1) begin
      n_err++;
      $display("FAIL super_disabled: got fault %b expected 1", r.bflt);
    end
    txn(32'h803FFFFC, 2'd0, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h803FFFFC || r.lat != 1 || r.rdc != 0) begin
      n_err++;
      $display("FAIL super_hit: got v%b %h lat %0d expected v1 803ffffc lat 1",
               r.got, r.pa, r.lat);
    end
  endtask

  task automatic test_faults();
    res_t r;
    do_reset();
    txn(32'h00401234, 2'd2, 1'b1, 2, 32'h80004, 32'h00020401, 32'h81004, 32'h048D1447,
        1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h0 || r.flt !== 1'b1) begin
      n_err++;
      $display("FAIL store_nod: got v%b %h f%b expected v1 0 f1", r.got, r.pa, r.flt);
    end
    // The faulting leaf was still filled: the load hits without a walk.
    txn(32'h00401234, 2'd1, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h12345234 || r.flt !== 1'b0 || r.rdc != 0) begin
      n_err++;
      $display("FAIL fill_on_fault: got v%b %h f%b rden %0d expected v1 12345234 f0 rden 0",
               r.got, r.pa, r.flt, r.rdc);
    end
    do_reset();
    txn(32'h00401234, 2'd1, 1'b1, 1, 32'h80004, 32'h00000000, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h0 || r.flt !== 1'b1 || r.lat != 0) begin
      n_err++;
      $display("FAIL pte_invalid: got v%b %h f%b lat %0d expected v1 0 f1 lat 0",
               r.got, r.pa, r.flt, r.lat);
    end
    txn(32'h00401234, 2'd1, 1'b1, 1, 32'h80004, 32'h00000005, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.flt !== 1'b1) begin
      n_err++;
      $display("FAIL pte_w_no_r: got v%b f%b expected v1 f1", r.got, r.flt);
    end
    txn(32'h00401234, 2'd0, 1'b1, 1, 32'h80004, 32'h00020449, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h0 || r.flt !== 1'b1) begin
      n_err++;
      $display("FAIL misaligned: got v%b %h f%b expected v1 0 f1", r.got, r.pa, r.flt);
    end
    txn(32'h00401234, 2'd0, 1'b1, 1, 32'h80004, 32'h00020449, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.rdc == 0 || r.flt !== 1'b1) begin
      n_err++;
      $display("FAIL misaligned_nofill: got v%b rden %0d f%b expected v1 rden>0 f1",
               r.got, r.rdc, r.flt);
    end
  endtask

  task automatic test_replacement();
    res_t r;
    logic [31:0] va;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      va = (32'(k) << 22) | 32'h123;
      txn(va, 2'd1, 1'b1, 1, 32'h80000 + 32'(4 * k), (32'(k) << 20) | 32'hCF, 0, 0,
          1'b0, 1'b0, r);
      n_vec++;
      if (!r.got || r.pa !== va || r.flt !== 1'b0) begin
        n_err++;
        $display("FAIL fill_page%0d: got v%b %h f%b expected v1 %h f0", k, r.got, r.pa, r.flt, va);
      end
    end
    txn(32'h00800123, 2'd1, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h00800123 || r.rdc != 0 || r.lat != 1) begin
      n_err++;
      $display("FAIL rr_keep: got v%b %h rden %0d lat %0d expected v1 00800123 rden 0 lat 1",
               r.got, r.pa, r.rdc, r.lat);
    end
    txn(32'h00400123, 2'd1, 1'b1, 1, 32'h80004, 32'h001000CF, 0, 0, 1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h00400123 || r.rdc == 0) begin
      n_err++;
      $display("FAIL rr_evict: got v%b %h rden %0d expected v1 00400123 rden>0",
               r.got, r.pa, r.rdc);
    end
  endtask

  task automatic test_flush();
    res_t r;
    do_reset();
    txn(32'h00401234, 2'd1, 1'b1, 2, 32'h80004, 32'h00020401, 32'h81004, 32'h048D14C7,
        1'b1, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h12345234 || r.flt !== 1'b0) begin
      n_err++;
      $display("FAIL flush_walk_resp: got v%b %h f%b expected v1 12345234 f0", r.got, r.pa, r.flt);
    end
    txn(32'h00401234, 2'd1, 1'b1, 2, 32'h80004, 32'h00020401, 32'h81004, 32'h048D14C7,
        1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h12345234 || r.rdc == 0) begin
      n_err++;
      $display("FAIL flush_walk_nofill: got v%b %h rden %0d expected v1 12345234 rden>0",
               r.got, r.pa, r.rdc);
    end
    FLUSH = 1'b1; @(negedge CLK); FLUSH = 1'b0;
    txn(32'h00401234, 2'd1, 1'b1, 2, 32'h80004, 32'h00020401, 32'h81004, 32'h048D14C7,
        1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.rdc == 0) begin
      n_err++;
      $display("FAIL flush_idle: got v%b rden %0d expected v1 rden>0", r.got, r.rdc);
    end
  endtask

  task automatic test_mismatch();
    res_t r;
    do_reset();
    txn(32'h00401234, 2'd1, 1'b1, 2, 32'h80004, 32'h00020401, 32'h81004, 32'h048D14C7,
        1'b0, 1'b1, r);
    n_vec++;
    if (r.mm_rden !== 1'b1 || r.mm_riaddr !== 32'h80004 || r.mm_ready !== 1'b0) begin
      n_err++;
      $display("FAIL roaddr_ignore: got rden %b riaddr %h ready %b expected 1 00080004 0",
               r.mm_rden, r.mm_riaddr, r.mm_ready);
    end
    n_vec++;
    if (!r.got || r.pa !== 32'h12345234 || r.flt !== 1'b0) begin
      n_err++;
      $display("FAIL roaddr_resume: got v%b %h f%b expected v1 12345234 f0", r.got, r.pa, r.flt);
    end
  endtask

  task automatic test_reset_mid_walk();
    res_t r;
    int seen;
    do_reset();
    SATP_MODE = 1'b1; REQ_VADDR = 32'h00401234; REQ_ACC = 2'd1; REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    for (int t = 0; t < 20 && !rden; t++) @(negedge CLK);
    n_vec++;
    if (rden !== 1'b1) begin
      n_err++;
      $display("FAIL rst_walk_start: got rden %b expected 1", rden);
    end
    RST = 1'b0;
    #1;
    n_vec++;
    if (rden !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_async: got rden %b ready %b expected 0 1", rden, req_ready);
    end
    seen = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK);
      if (resp_valid) seen++;
    end
    RST = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK);
      if (resp_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_no_resp: got %0d responses expected 0", seen);
    end
    txn(32'h00401234, 2'd1, 1'b1, 2, 32'h80004, 32'h00020401, 32'h81004, 32'h048D14C7,
        1'b0, 1'b0, r);
    n_vec++;
    if (!r.got || r.pa !== 32'h12345234 || r.rdc == 0) begin
      n_err++;
      $display("FAIL rst_recover: got v%b %h rden %0d expected v1 12345234 rden>0",
               r.got, r.pa, r.rdc);
    end
  endtask

  initial begin
    RST = 1'b1; SATP_MODE = 1'b0; SATP_PPN = 22'h80; FLUSH = 1'b0; REQ_VALID = 1'b0;
    REQ_VADDR = '0; REQ_ACC = '0; ROADDR = '0; RVALID = 1'b0; RDATA = '0;
    @(negedge CLK);
    test_reset();
    test_bare();
    test_two_level();
    test_superpage();
    test_faults();
    test_replacement();
    test_flush();
    test_mismatch();
    test_reset_mid_walk();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
